// File: rtl/dma_reg_pkg.sv
// Shared definitions for the DMA register responder:
// register offsets, CTRL/STATUS bit positions and FSM states.
package dma_reg_pkg;

    localparam logic [7:0] CTRL_OFF = 8'h00;
    localparam logic [7:0] SRC_OFF  = 8'h04;
    localparam logic [7:0] DST_OFF  = 8'h08;
    localparam logic [7:0] LEN_OFF  = 8'h0C;
    localparam logic [7:0] STAT_OFF = 8'h10;
    localparam logic [7:0] PROG_OFF = 8'h14;
    localparam logic [7:0] ID_OFF   = 8'h18;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;
    localparam int STAT_REM  = 16;

    typedef enum logic {
        IDLE,
        RUN
    } dma_state_e;

endpackage

// File: rtl/dma_reg_responder_beat_timer.sv
// Step counter: raises beat on the last of every STEP_CYCLES
// enabled cycles.
module dma_beat_timer #(
    parameter int STEP_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic beat
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign beat = en & (cnt == LAST);

endmodule

// File: rtl/dma_reg_responder.sv
// DMA register-bus responder: config registers, transfer FSM
// and registered read data.
import dma_reg_pkg::*;

module dma_reg_responder #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          LEN_W       = 16,
    parameter int          STEP_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hD3A0_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              beat,
    output logic [ADDR_W-1:0] cur_src,
    output logic [ADDR_W-1:0] cur_dst,
    output logic              irq
);

    dma_state_e state, state_nxt;

    logic              irq_en, done, err;
    logic [ADDR_W-1:0] src, dst;
    logic [LEN_W-1:0]  len, remaining, progress;

    logic [7:0]        off;
    logic              unused_addr;
    logic              mapped;
    logic [DATA_W-1:0] rd_mux;

    logic wr_ctrl, wr_src, wr_dst, wr_len, wr_stat;
    logic start_req, abort_hit, start_ok;
    logic timer_beat, beat_hit, last_beat, err_set;

    assign off         = {addr[7:2], 2'b00};
    assign unused_addr = ^{addr[ADDR_W-1:8], addr[1:0]};

    assign wr_ctrl = wr_en && (off == CTRL_OFF);
    assign wr_src  = wr_en && (off == SRC_OFF);
    assign wr_dst  = wr_en && (off == DST_OFF);
    assign wr_len  = wr_en && (off == LEN_OFF);
    assign wr_stat = wr_en && (off == STAT_OFF);

    assign busy = (state == RUN);
    assign irq  = irq_en & done;

    // ABORT beats START when both bits land in one write
    assign start_req = wr_ctrl & wdata[CTRL_START] & ~wdata[CTRL_ABORT];
    assign abort_hit = wr_ctrl & wdata[CTRL_ABORT] & busy;
    assign start_ok  = start_req & ~busy & (len != '0);

    dma_beat_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (busy),
        .clr (abort_hit),
        .beat(timer_beat)
    );

    assign beat_hit  = timer_beat & ~abort_hit & ~rst;
    assign beat      = beat_hit;
    assign last_beat = beat_hit & (remaining == LEN_W'(1));

    assign err_set = (start_req & (busy | (len == '0)))
                   | abort_hit
                   | ((wr_src | wr_dst | wr_len) & busy)
                   | (wr_en & ~mapped);

    always_comb begin
        rd_mux = '0;
        mapped = 1'b1;
        unique case (off)
            CTRL_OFF: rd_mux[CTRL_IRQ_EN] = irq_en;
            SRC_OFF:  rd_mux = DATA_W'(src);
            DST_OFF:  rd_mux = DATA_W'(dst);
            LEN_OFF:  rd_mux = DATA_W'(len);
            STAT_OFF: begin
                rd_mux[STAT_BUSY]           = busy;
                rd_mux[STAT_DONE]           = done;
                rd_mux[STAT_ERR]            = err;
                rd_mux[STAT_REM +: LEN_W]   = remaining;
            end
            PROG_OFF: rd_mux = DATA_W'(progress);
            ID_OFF:   rd_mux = DATA_W'(ID_VALUE);
            default:  mapped = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_ok) state_nxt = RUN;
            RUN:  if (abort_hit || last_beat) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            src       <= '0;
            dst       <= '0;
            len       <= '0;
            remaining <= '0;
            progress  <= '0;
            cur_src   <= '0;
            cur_dst   <= '0;
            rdata     <= '0;
        end else begin
            if (wr_ctrl) irq_en <= wdata[CTRL_IRQ_EN];
            if (wr_src && !busy) src <= ADDR_W'(wdata);
            if (wr_dst && !busy) dst <= ADDR_W'(wdata);
            if (wr_len && !busy) len <= LEN_W'(wdata);

            if (start_ok) begin
                cur_src   <= src;
                cur_dst   <= dst;
                remaining <= len;
                progress  <= '0;
            end else if (beat_hit) begin
                cur_src   <= cur_src + ADDR_W'(4);
                cur_dst   <= cur_dst + ADDR_W'(4);
                remaining <= remaining - 1'b1;
                progress  <= progress + 1'b1;
            end

            // hardware sets take priority over W1C clears
            if (last_beat) begin
                done <= 1'b1;
            end else if (start_ok || (wr_stat && wdata[STAT_DONE])) begin
                done <= 1'b0;
            end

            if (err_set) begin
                err <= 1'b1;
            end else if (wr_stat && wdata[STAT_ERR]) begin
                err <= 1'b0;
            end

            if (rd_en) rdata <= rd_mux;
        end
    end

endmodule
